// File: rtl/core_pkg.sv
// Shared definitions for the multicycle RV32I core: datapath width, reset
// constants and the fetch FSM state type.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ERR
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port: a ready/valid request from the fetch unit,
// with the word returned in the same cycle that mem_ready is high.
interface fetch_unit_if;
  import core_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with the PCSrc next-PC mux. Low address bits are
// stored untouched; alignment is judged by the fetch FSM when a fetch starts.
module pc_reg import core_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            PCEn,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (PCEn) begin
      pc <= PCSrc ? alu_out : alu_result;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC, old PC and IR, issues one memory read per
// rising IRWrite edge and latches a sticky error on timeout or misaligned PC.
module fetch_unit import core_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int              TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               IRWrite,
  input  logic               PCEn,
  input  logic               PCSrc,
  input  logic [XLEN-1:0]    alu_result,
  input  logic [XLEN-1:0]    alu_out,
  fetch_unit_if.master       mem,
  output logic [XLEN-1:0]    instruction,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    old_pc,
  output logic               instr_valid,
  output logic               fetch_stall,
  output logic               fetch_err
);

  localparam int              CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  fetch_state_t    state, state_next;
  logic            irw_q;
  logic            req, req_next;
  logic [XLEN-1:0] addr, addr_next;
  logic [XLEN-1:0] ir, ir_next;
  logic [XLEN-1:0] opc, opc_next;
  logic            valid_next;
  logic            stall_next;
  logic            err_next;
  logic [CW-1:0]   cnt, cnt_next;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .PCEn       (PCEn),
    .PCSrc      (PCSrc),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .pc         (pc)
  );

  // The fetch address comes from the PC before any same-edge PCEn update.
  always_comb begin
    state_next = state;
    req_next   = req;
    addr_next  = addr;
    ir_next    = ir;
    opc_next   = opc;
    valid_next = 1'b0;
    stall_next = fetch_stall;
    err_next   = fetch_err;
    cnt_next   = cnt;

    case (state)
      IDLE: begin
        if (IRWrite && !irw_q) begin
          if (pc[1:0] != 2'b00) begin
            state_next = ERR;
            err_next   = 1'b1;
            ir_next    = NOP_INSTR;
          end else begin
            state_next = REQ;
            req_next   = 1'b1;
            addr_next  = pc;
            cnt_next   = '0;
            stall_next = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          state_next = IDLE;
          ir_next    = mem.mem_rdata;
          opc_next   = addr;
          valid_next = 1'b1;
          req_next   = 1'b0;
          stall_next = 1'b0;
        end else begin
          cnt_next = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state_next = ERR;
            err_next   = 1'b1;
            req_next   = 1'b0;
            ir_next    = NOP_INSTR;
            stall_next = 1'b0;
          end
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next = ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      irw_q       <= 1'b0;
      req         <= 1'b0;
      addr        <= '0;
      ir          <= NOP_INSTR;
      opc         <= RESET_PC;
      instr_valid <= 1'b0;
      fetch_stall <= 1'b0;
      fetch_err   <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_next;
      irw_q       <= IRWrite;
      req         <= req_next;
      addr        <= addr_next;
      ir          <= ir_next;
      opc         <= opc_next;
      instr_valid <= valid_next;
      fetch_stall <= stall_next;
      fetch_err   <= err_next;
      cnt         <= cnt_next;
    end
  end

  assign mem.mem_req  = req;
  assign mem.mem_addr = addr;
  assign instruction  = ir;
  assign old_pc       = opc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// timeout/misalign/reset sequences, then random traffic against a queue-free model.
module tb_fetch_unit;
  import core_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n, IRWrite, PCEn, PCSrc;
  logic [31:0] alu_result, alu_out;
  logic [31:0] instruction, pc, old_pc;
  logic        instr_valid, fetch_stall, fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_unit_if mem ();

  fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .IRWrite     (IRWrite),
    .PCEn        (PCEn),
    .PCSrc       (PCSrc),
    .alu_result  (alu_result),
    .alu_out     (alu_out),
    .mem         (mem),
    .instruction (instruction),
    .pc          (pc),
    .old_pc      (old_pc),
    .instr_valid (instr_valid),
    .fetch_stall (fetch_stall),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, irw, pcen, pcsrc, rdy;
    logic [31:0] ar, ao, rdata;
    logic [31:0] e_pc, e_instr, e_old_pc, e_addr;
    logic        e_req, e_valid, e_err;
  } vec_t;

  // Reference model: a fetch is either pending (with its address and the
  // number of cycles it has waited) or not; error is a one-way latch.
  logic [31:0] m_pc, m_old_pc, m_ir, m_addr;
  bit          m_err, m_busy, m_valid, m_irw_prev;
  int          m_waited;

  function automatic vec_t v(logic rst_n, logic irw, logic pcen, logic pcsrc,
                             logic [31:0] ar, logic [31:0] ao, logic rdy, logic [31:0] rdata,
                             logic [31:0] e_pc, logic [31:0] e_instr, logic [31:0] e_old_pc,
                             logic e_req, logic [31:0] e_addr, logic e_valid, logic e_err);
    vec_t t;
    t.rst_n = rst_n; t.irw = irw; t.pcen = pcen; t.pcsrc = pcsrc;
    t.ar = ar; t.ao = ao; t.rdy = rdy; t.rdata = rdata;
    t.e_pc = e_pc; t.e_instr = e_instr; t.e_old_pc = e_old_pc;
    t.e_req = e_req; t.e_addr = e_addr; t.e_valid = e_valid; t.e_err = e_err;
    return t;
  endfunction

  task automatic drive(logic rst_n, logic irw, logic pcen, logic pcsrc,
                       logic [31:0] ar, logic [31:0] ao, logic rdy, logic [31:0] rdata);
    reset_n       = rst_n;
    IRWrite       = irw;
    PCEn          = pcen;
    PCSrc         = pcsrc;
    alu_result    = ar;
    alu_out       = ao;
    mem.mem_ready = rdy;
    mem.mem_rdata = rdata;
  endtask

  task automatic applyStimulus(vec_t t);
    drive(t.rst_n, t.irw, t.pcen, t.pcsrc, t.ar, t.ao, t.rdy, t.rdata);
  endtask

  task automatic modelStep();
    bit start;
    if (!reset_n) begin
      m_pc = RESET_PC_DEFAULT; m_old_pc = RESET_PC_DEFAULT; m_ir = NOP_INSTR_DEFAULT;
      m_err = 0; m_busy = 0; m_valid = 0; m_irw_prev = 0; m_waited = 0; m_addr = '0;
    end else begin
      start   = IRWrite && !m_irw_prev;
      m_valid = 0;
      if (m_busy) begin
        if (mem.mem_ready) begin
          m_ir = mem.mem_rdata; m_old_pc = m_addr; m_valid = 1; m_busy = 0;
        end else begin
          m_waited++;
          if (m_waited == TIMEOUT) begin
            m_err = 1; m_busy = 0; m_ir = NOP_INSTR_DEFAULT;
          end
        end
      end else if (start && !m_err) begin
        if (m_pc % 4 != 0) begin
          m_err = 1; m_ir = NOP_INSTR_DEFAULT;
        end else begin
          m_busy = 1; m_addr = m_pc; m_waited = 0;
        end
      end
      if (PCEn) m_pc = PCSrc ? alu_out : alu_result;
      m_irw_prev = IRWrite;
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkVector(int i, vec_t t);
    checkOutput($sformatf("row%0d.pc", i), pc, t.e_pc);
    checkOutput($sformatf("row%0d.instruction", i), instruction, t.e_instr);
    checkOutput($sformatf("row%0d.old_pc", i), old_pc, t.e_old_pc);
    checkOutput($sformatf("row%0d.mem_req", i), 32'(mem.mem_req), 32'(t.e_req));
    checkOutput($sformatf("row%0d.fetch_stall", i), 32'(fetch_stall), 32'(t.e_req));
    checkOutput($sformatf("row%0d.instr_valid", i), 32'(instr_valid), 32'(t.e_valid));
    checkOutput($sformatf("row%0d.fetch_err", i), 32'(fetch_err), 32'(t.e_err));
    if (t.e_req) checkOutput($sformatf("row%0d.mem_addr", i), mem.mem_addr, t.e_addr);
  endtask

  task automatic checkAgainstModel(int cyc);
    checkOutput($sformatf("rnd%0d.pc", cyc), pc, m_pc);
    checkOutput($sformatf("rnd%0d.instruction", cyc), instruction, m_ir);
    checkOutput($sformatf("rnd%0d.old_pc", cyc), old_pc, m_old_pc);
    checkOutput($sformatf("rnd%0d.mem_req", cyc), 32'(mem.mem_req), 32'(m_busy));
    checkOutput($sformatf("rnd%0d.fetch_stall", cyc), 32'(fetch_stall), 32'(m_busy));
    checkOutput($sformatf("rnd%0d.instr_valid", cyc), 32'(instr_valid), 32'(m_valid));
    checkOutput($sformatf("rnd%0d.fetch_err", cyc), 32'(fetch_err), 32'(m_err));
    if (m_busy) checkOutput($sformatf("rnd%0d.mem_addr", cyc), mem.mem_addr, m_addr);
  endtask

  task automatic doReset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  vec_t vecs[18];

  initial begin
    logic [31:0] ar, ao;
    logic        irw;

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] starting fetch_unit bench");

    //             rst irw en src ar     ao      rdy rdata          pc      instr          old_pc  req addr    vld err
    vecs[0]  = v(0, 0, 0, 0, 0,      0,      0, 0,             32'h0,  32'h13,        32'h0,  0, 0,       0, 0);
    vecs[1]  = v(0, 0, 0, 0, 0,      0,      0, 0,             32'h0,  32'h13,        32'h0,  0, 0,       0, 0);
    vecs[2]  = v(1, 1, 0, 0, 0,      0,      0, 0,             32'h0,  32'h13,        32'h0,  1, 32'h0,   0, 0);
    vecs[3]  = v(1, 1, 0, 0, 0,      0,      0, 0,             32'h0,  32'h13,        32'h0,  1, 32'h0,   0, 0);
    vecs[4]  = v(1, 1, 0, 0, 0,      0,      0, 0,             32'h0,  32'h13,        32'h0,  1, 32'h0,   0, 0);
    vecs[5]  = v(1, 1, 0, 0, 0,      0,      0, 0,             32'h0,  32'h13,        32'h0,  1, 32'h0,   0, 0);
    vecs[6]  = v(1, 1, 0, 0, 0,      0,      1, 32'h0020_8133, 32'h0,  32'h0020_8133, 32'h0,  0, 0,       1, 0);
    vecs[7]  = v(1, 0, 0, 0, 0,      0,      0, 0,             32'h0,  32'h0020_8133, 32'h0,  0, 0,       0, 0);
    vecs[8]  = v(1, 0, 1, 0, 32'h4,  0,      0, 0,             32'h4,  32'h0020_8133, 32'h0,  0, 0,       0, 0);
    vecs[9]  = v(1, 0, 1, 1, 32'h4,  32'h100,0, 0,             32'h100,32'h0020_8133, 32'h0,  0, 0,       0, 0);
    vecs[10] = v(1, 1, 0, 0, 0,      0,      0, 0,             32'h100,32'h0020_8133, 32'h0,  1, 32'h100, 0, 0);
    vecs[11] = v(1, 1, 0, 0, 0,      0,      1, 32'h0041_0193, 32'h100,32'h0041_0193, 32'h100,0, 0,       1, 0);
    vecs[12] = v(1, 0, 0, 0, 0,      0,      0, 0,             32'h100,32'h0041_0193, 32'h100,0, 0,       0, 0);
    vecs[13] = v(1, 0, 1, 0, 32'h4,  0,      0, 0,             32'h4,  32'h0041_0193, 32'h100,0, 0,       0, 0);
    vecs[14] = v(1, 1, 1, 0, 32'h8,  0,      0, 0,             32'h8,  32'h0041_0193, 32'h100,1, 32'h4,   0, 0);
    vecs[15] = v(1, 1, 0, 0, 0,      0,      0, 0,             32'h8,  32'h0041_0193, 32'h100,1, 32'h4,   0, 0);
    vecs[16] = v(1, 1, 0, 0, 0,      0,      1, 32'h00c5_8593, 32'h8,  32'h00c5_8593, 32'h4,  0, 0,       1, 0);
    vecs[17] = v(1, 0, 0, 0, 0,      0,      0, 0,             32'h8,  32'h00c5_8593, 32'h4,  0, 0,       0, 0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkVector(i, vecs[i]);
    end

    // Timeout: 16 consecutive not-ready cycles, then the error is terminal.
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("to.start_req", 32'(mem.mem_req), 32'd1);
    checkOutput("to.start_addr", mem.mem_addr, 32'h8);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      checkOutput($sformatf("to.wait%0d.req", i), 32'(mem.mem_req), 32'd1);
      checkOutput($sformatf("to.wait%0d.err", i), 32'(fetch_err), 32'd0);
    end
    tick();
    checkOutput("to.err", 32'(fetch_err), 32'd1);
    checkOutput("to.req", 32'(mem.mem_req), 32'd0);
    checkOutput("to.stall", 32'(fetch_stall), 32'd0);
    checkOutput("to.instr", instruction, 32'h13);
    drive(1, 0, 0, 0, 0, 0, 1, 32'hdead_beef);
    tick();
    drive(1, 1, 0, 0, 0, 0, 1, 32'hdead_beef);
    tick();
    checkOutput("to.after_req", 32'(mem.mem_req), 32'd0);
    tick();
    checkOutput("to.after_valid", 32'(instr_valid), 32'd0);
    checkOutput("to.after_instr", instruction, 32'h13);
    checkOutput("to.after_err", 32'(fetch_err), 32'd1);

    // Ready arriving on the last allowed cycle still completes the fetch.
    doReset();
    checkOutput("last.reset_err", 32'(fetch_err), 32'd0);
    checkOutput("last.reset_pc", pc, 32'h0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 1; i < TIMEOUT; i++) tick();
    checkOutput("last.still_req", 32'(mem.mem_req), 32'd1);
    drive(1, 1, 0, 0, 0, 0, 1, 32'h00a0_0093);
    tick();
    checkOutput("last.err", 32'(fetch_err), 32'd0);
    checkOutput("last.valid", 32'(instr_valid), 32'd1);
    checkOutput("last.instr", instruction, 32'h00a0_0093);
    checkOutput("last.req", 32'(mem.mem_req), 32'd0);

    // Misaligned PC is flagged at fetch start with no request issued.
    drive(1, 0, 1, 0, 32'h102, 0, 0, 0);
    tick();
    checkOutput("mis.pc", pc, 32'h102);
    checkOutput("mis.err_before", 32'(fetch_err), 32'd0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("mis.err", 32'(fetch_err), 32'd1);
    checkOutput("mis.req", 32'(mem.mem_req), 32'd0);
    checkOutput("mis.stall", 32'(fetch_stall), 32'd0);
    checkOutput("mis.instr", instruction, 32'h13);
    tick();
    checkOutput("mis.req_later", 32'(mem.mem_req), 32'd0);

    // Reset during an outstanding request abandons it at the same edge.
    doReset();
    drive(1, 0, 1, 1, 0, 32'h40, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rst.req_before", 32'(mem.mem_req), 32'd1);
    checkOutput("rst.addr_before", mem.mem_addr, 32'h40);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rst.req", 32'(mem.mem_req), 32'd0);
    checkOutput("rst.stall", 32'(fetch_stall), 32'd0);
    checkOutput("rst.pc", pc, 32'h0);
    checkOutput("rst.err", 32'(fetch_err), 32'd0);
    checkOutput("rst.instr", instruction, 32'h13);

    // Random traffic compared cycle by cycle with the model.
    doReset();
    irw = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic rst_n;
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) irw = ~irw;
      if (!rst_n) irw = 1'b0;
      ar = $urandom & 32'hFFFF_FFFC;
      ao = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 199) == 0) ar[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) ar = 32'h0000_0000;
      if ($urandom_range(0, 31) == 0) ao = 32'hFFFF_FFFC;
      drive(rst_n, irw, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            ar, ao, ($urandom_range(0, 2) == 0), $urandom);
      tick();
      checkAgainstModel(cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
